// File: rtl/softmax_pkg.sv
// rtl/softmax_pkg.sv - softmax controller phase encoding, default parameters and length rule
package softmax_pkg;

    localparam int N_MAX_DEF   = 16;
    localparam int ADDR_W_DEF  = 4;
    localparam int EXP_LAT_DEF = 4;
    localparam int DIV_LAT_DEF = 6;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_MAX        = 3'd1,
        ST_SUM        = 3'd2,
        ST_DRAIN_SUM  = 3'd3,
        ST_NORM       = 3'd4,
        ST_DRAIN_NORM = 3'd5,
        ST_DONE       = 3'd6
    } state_e;

    function automatic logic len_ok(input int unsigned len, input int unsigned n_max);
        return (len != 0) && (len <= n_max);
    endfunction

endpackage

// File: rtl/softmax_valid_pipe.sv
// rtl/softmax_valid_pipe.sv - fixed-depth {valid, addr} delay line, flushed by reset
module softmax_valid_pipe #(
    parameter int DEPTH = 5,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          valid_i,
    input  logic [AW-1:0] addr_i,
    output logic          valid_o,
    output logic [AW-1:0] addr_o,
    output logic          pending_o
);

    logic [DEPTH-1:0] vld_q;
    logic [AW-1:0]    addr_q [DEPTH];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            vld_q <= '0;
            for (int i = 0; i < DEPTH; i++) addr_q[i] <= '0;
        end else begin
            vld_q[0]  <= valid_i;
            addr_q[0] <= addr_i;
            for (int i = 1; i < DEPTH; i++) begin
                vld_q[i]  <= vld_q[i-1];
                addr_q[i] <= addr_q[i-1];
            end
        end
    end

    assign valid_o = vld_q[DEPTH-1];
    assign addr_o  = addr_q[DEPTH-1];

    // Tags still in flight behind the output stage; zero means the line empties next cycle.
    always_comb begin
        pending_o = 1'b0;
        for (int i = 0; i < DEPTH - 1; i++) pending_o = pending_o | vld_q[i];
    end

endmodule

// File: rtl/softmax_controller.sv
// rtl/softmax_controller.sv - softmax pass sequencer; SOFTMAX_MAX_SUB_EN enables the max pass
module softmax_controller
    import softmax_pkg::*;
#(
    parameter int N_MAX   = N_MAX_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int EXP_LAT = EXP_LAT_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   len,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              max_en,
    output logic              max_clr,
    output logic              sub_max_en,
    output logic              acc_en,
    output logic              acc_clr,
    output logic              div_en,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [2:0]        phase
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic              last_elem, start_ok;

    logic              exp_in_valid, exp_out_valid, exp_pending;
    logic [ADDR_W-1:0] exp_out_addr;
    logic              wr_out_valid, wr_pending;
    logic [ADDR_W-1:0] wr_out_addr;

    logic              busy_d, done_d, err_d, rd_en_d, max_en_d, max_clr_d, sub_max_en_d;
    logic              acc_en_d, acc_clr_d, div_en_d, wr_en_d;
    logic [ADDR_W-1:0] rd_addr_d, wr_addr_d;

    assign last_elem    = ({1'b0, cnt_q} == (len_q - 1'b1));
    assign start_ok     = len_ok(32'(len), N_MAX);
    assign exp_in_valid = (state_q == ST_SUM) || (state_q == ST_NORM);

    softmax_valid_pipe #(.DEPTH(1 + EXP_LAT), .AW(ADDR_W)) u_exp_pipe (
        .clk       (clk),
        .resetn    (reset),
        .valid_i   (exp_in_valid),
        .addr_i    (cnt_q),
        .valid_o   (exp_out_valid),
        .addr_o    (exp_out_addr),
        .pending_o (exp_pending)
    );

    softmax_valid_pipe #(.DEPTH(DIV_LAT), .AW(ADDR_W)) u_div_pipe (
        .clk       (clk),
        .resetn    (reset),
        .valid_i   (div_en_d),
        .addr_i    (exp_out_addr),
        .valid_o   (wr_out_valid),
        .addr_o    (wr_out_addr),
        .pending_o (wr_pending)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            len_q      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            rd_en      <= 1'b0;
            rd_addr    <= '0;
            max_en     <= 1'b0;
            max_clr    <= 1'b0;
            sub_max_en <= 1'b0;
            acc_en     <= 1'b0;
            acc_clr    <= 1'b0;
            div_en     <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            phase      <= ST_IDLE;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            busy       <= busy_d;
            done       <= done_d;
            err        <= err_d;
            rd_en      <= rd_en_d;
            rd_addr    <= rd_addr_d;
            max_en     <= max_en_d;
            max_clr    <= max_clr_d;
            sub_max_en <= sub_max_en_d;
            acc_en     <= acc_en_d;
            acc_clr    <= acc_clr_d;
            div_en     <= div_en_d;
            wr_en      <= wr_en_d;
            wr_addr    <= wr_addr_d;
            phase      <= state_q;
        end
    end

    // Drain exits one cycle early: the last tag leaves the output stage on the transition edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (start && start_ok) begin
                    len_d = len;
`ifdef SOFTMAX_MAX_SUB_EN
                    state_d = ST_MAX;
`else
                    state_d = ST_SUM;
`endif
                end
            end
`ifdef SOFTMAX_MAX_SUB_EN
            ST_MAX: begin
                cnt_d = last_elem ? '0 : cnt_q + 1'b1;
                if (last_elem) state_d = ST_SUM;
            end
`endif
            ST_SUM: begin
                cnt_d = last_elem ? '0 : cnt_q + 1'b1;
                if (last_elem) state_d = ST_DRAIN_SUM;
            end
            ST_DRAIN_SUM: begin
                if (!exp_pending) state_d = ST_NORM;
            end
            ST_NORM: begin
                cnt_d = last_elem ? '0 : cnt_q + 1'b1;
                if (last_elem) state_d = ST_DRAIN_NORM;
            end
            ST_DRAIN_NORM: begin
                if (!exp_pending && !exp_out_valid && !wr_pending) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy_d    = (state_q != ST_IDLE) && (state_q != ST_DONE);
        done_d    = (state_q == ST_DONE);
        err_d     = (state_q == ST_IDLE) && start && !start_ok;
        rd_en_d   = exp_in_valid;
        rd_addr_d = '0;
`ifdef SOFTMAX_MAX_SUB_EN
        rd_en_d      = exp_in_valid || (state_q == ST_MAX);
        max_en_d     = (state_q == ST_MAX);
        max_clr_d    = (state_q == ST_MAX) && (cnt_q == '0);
        sub_max_en_d = exp_in_valid;
`else
        max_en_d     = 1'b0;
        max_clr_d    = 1'b0;
        sub_max_en_d = 1'b0;
`endif
        if (rd_en_d) rd_addr_d = cnt_q;
        acc_en_d  = exp_out_valid && ((state_q == ST_SUM) || (state_q == ST_DRAIN_SUM));
        acc_clr_d = acc_en_d && (exp_out_addr == '0);
        div_en_d  = exp_out_valid && ((state_q == ST_NORM) || (state_q == ST_DRAIN_NORM));
        wr_en_d   = wr_out_valid;
        wr_addr_d = wr_out_valid ? wr_out_addr : '0;
    end

endmodule

// File: tb/tb_softmax_controller.sv
// tb/tb_softmax_controller.sv - randomized cycle-accurate check of softmax_controller
module tb_softmax_controller;

    localparam int EXP = 4;
    localparam int DIV = 6;
`ifdef SOFTMAX_MAX_SUB_EN
    localparam bit MAXP = 1'b1;
`else
    localparam bit MAXP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       resetn, start;
    logic [4:0] len;
    logic       busy, done, err, rd_en, max_en, max_clr, sub_max_en;
    logic       acc_en, acc_clr, div_en, wr_en;
    logic [3:0] rd_addr, wr_addr;
    logic [2:0] phase;
    logic [18:0] dut_vec;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    softmax_controller #(.N_MAX(16), .ADDR_W(4), .EXP_LAT(EXP), .DIV_LAT(DIV)) dut (
        .clk(clk), .reset(resetn), .start(start), .len(len),
        .busy(busy), .done(done), .err(err), .rd_en(rd_en), .rd_addr(rd_addr),
        .max_en(max_en), .max_clr(max_clr), .sub_max_en(sub_max_en),
        .acc_en(acc_en), .acc_clr(acc_clr), .div_en(div_en),
        .wr_en(wr_en), .wr_addr(wr_addr), .phase(phase)
    );

    assign dut_vec = {busy, done, err, rd_en, rd_addr, max_en, max_clr, sub_max_en,
                      acc_en, acc_clr, div_en, wr_en, wr_addr};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit in_win(input int k, input int s, input int n);
        return (k >= s) && (k < s + n);
    endfunction

    // Expected outputs in cycle k after a start accepted at cycle 0, from the pass timing rules.
    function automatic logic [18:0] expect_vec(input int k, input int L);
        int m, s0, a0, n0, d0, w0, dn;
        logic [18:0] v;
        m  = MAXP ? L : 0;
        s0 = m + 1;
        a0 = s0 + 1 + EXP;
        n0 = m + L + EXP + 2;
        d0 = n0 + 1 + EXP;
        w0 = d0 + DIV;
        dn = m + 2 * L + 2 * EXP + DIV + 3;
        v = '0;
        v[18] = (k >= 1) && (k < dn);
        v[17] = (k == dn);
        if (in_win(k, 1, m))  begin v[15] = 1'b1; v[14:11] = 4'(k - 1); v[10] = 1'b1; v[9] = (k == 1); end
        if (in_win(k, s0, L)) begin v[15] = 1'b1; v[14:11] = 4'(k - s0); v[8] = MAXP; end
        if (in_win(k, n0, L)) begin v[15] = 1'b1; v[14:11] = 4'(k - n0); v[8] = MAXP; end
        if (in_win(k, a0, L)) begin v[7] = 1'b1; v[6] = (k == a0); end
        if (in_win(k, d0, L)) v[5] = 1'b1;
        if (in_win(k, w0, L)) begin v[4] = 1'b1; v[3:0] = 4'(k - w0); end
        return v;
    endfunction

    task automatic accept(input int L);
        @(negedge clk);
        start = 1'b1;
        len   = 5'(L);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_check(input int L, input bit noise);
        int dn;
        dn = (MAXP ? L : 0) + 2 * L + 2 * EXP + DIV + 3;
        accept(L);
        check($sformatf("L%0d c0", L), 32'(dut_vec), 32'(expect_vec(0, L)));
        for (int k = 1; k <= dn + 3; k++) begin
            @(negedge clk);
            check($sformatf("L%0d c%0d", L, k), 32'(dut_vec), 32'(expect_vec(k, L)));
            if (k == 1)      check("phase_first", 32'(phase), MAXP ? 32'd1 : 32'd2);
            if (k == dn)     check("phase_done", 32'(phase), 32'd6);
            if (k == dn + 2) check("phase_idle", 32'(phase), 32'd0);
            start = 1'b0;
            if (noise && k < dn) begin
                start = (k == dn - 1) ? 1'b1 : 1'($urandom_range(0, 1));
                len   = 5'($urandom_range(0, 31));
            end
        end
    endtask

    task automatic err_check(input int L);
        accept(L);
        check($sformatf("err L%0d", L), 32'(dut_vec), 32'h1_0000);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check($sformatf("err L%0d c%0d", L, k), 32'(dut_vec), 32'd0);
        end
        check("err_phase", 32'(phase), 32'd0);
    endtask

    task automatic abort_check();
        int L, r, wr_seen;
        L = 8;
        r = (MAXP ? L : 0) + L + EXP + 2 + 3;
        accept(L);
        for (int k = 1; k <= r; k++) begin
            @(negedge clk);
            check($sformatf("abort c%0d", k), 32'(dut_vec), 32'(expect_vec(k, L)));
        end
        resetn = 1'b0;
        @(negedge clk);
        check("abort_outputs", 32'(dut_vec), 32'd0);
        check("abort_phase", 32'(phase), 32'd0);
        resetn  = 1'b1;
        wr_seen = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            wr_seen += int'(wr_en) + int'(busy) + int'(done);
        end
        check("abort_quiet", 32'(wr_seen), 32'd0);
    endtask

    initial begin
        resetn = 1'b0;
        start  = 1'b0;
        len    = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", 32'(dut_vec), 32'd0);
        check("reset_phase", 32'(phase), 32'd0);
        resetn = 1'b1;

        run_check(4, 1'b0);
        run_check(1, 1'b0);
        run_check(16, 1'b0);
        err_check(0);
        err_check(17);
        for (int i = 0; i < 6; i++) run_check(int'($urandom_range(1, 16)), 1'b1);
        abort_check();
        run_check(5, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
